issue_ctrl: RTL and testbench

- Issue-stage sequencer in front of the register status table.
- Allocates ROB tags in order and decides whether the instruction in issue fires this cycle; drives the regstat write port (issue_writes/issue_dest/issue_ROB) and the pipeline stall.
- Retires tags in order on commit.
- On a mispredict flush, clears all tags and holds issue off while the regstat table is cleared.

---
 rtl/issue_ctrl_pkg.sv | 34 +++
 rtl/issue_ctrl_tag_ring_ptr.sv | 38 +++
 rtl/issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_issue_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the issue-stage sequencer.
// Holds the ROB sizing, the tag type, the sequencer state enum and the
// regstat write bundle, plus a saturating-increment helper.
package issue_ctrl_pkg;

  localparam int ROB_DEPTH    = 16;
  localparam int TAG_W        = $clog2(ROB_DEPTH);
  localparam int FLUSH_CYCLES = 1;
  // Flush counter holds FLUSH_CYCLES-1, and FLUSH_CYCLES is at most 7.
  localparam int FCNT_W       = 3;

  typedef logic [TAG_W-1:0] rob_tag_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } issue_state_e;

  // One regstat write: enable, destination register, owning ROB tag.
  typedef struct packed {
    logic       writes;
    logic [4:0] dest;
    rob_tag_t   rob;
  } regstat_wr_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/issue_ctrl_tag_ring_ptr.sv
// Wrapping ring pointer used for the ROB head and tail.
// Ports: clk/reset (sync, active-high), clr_i (sync clear to 0),
//        inc_i (advance by one, wrapping mod 2**TAG_W), ptr_o (current value).
module tag_ring_ptr #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [TAG_W-1:0] ptr_o
);

  logic [TAG_W-1:0] ptr_q;
  logic [TAG_W-1:0] ptr_d;

  // Clear wins over increment; the ring size is a power of two, so plain
  // overflow of the adder is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + {{(TAG_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue-stage sequencer: allocates ROB tags in order, decides whether the
// instruction in issue fires, drives the regstat write port and the stall,
// retires tags in order on commit and sequences the mispredict flush.
// Ports: clk/reset (sync, active-high); flush; instr_* / rs_avail from decode;
//        commit_valid/commit_rob from the ROB head; issue_* regstat write port;
//        stall, regstat_clear, rob_count/full/empty, commit_err pulse.
// Optional: define ISSUE_CTRL_STATS_EN to add saturating stall/flush counters
//        (stat_full_stalls, stat_rs_stalls, stat_flushes).
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH    = issue_ctrl_pkg::ROB_DEPTH,
  parameter int TAG_W        = issue_ctrl_pkg::TAG_W,
  parameter int FLUSH_CYCLES = issue_ctrl_pkg::FLUSH_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             instr_valid,
  input  logic             instr_writes_rd,
  input  logic [4:0]       instr_rd,
  input  logic             rs_avail,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_rob,
  output logic             issue_fire,
  output logic [TAG_W-1:0] issue_rob,
  output logic             issue_writes,
  output logic [4:0]       issue_dest,
  output logic             stall,
  output logic             regstat_clear,
  output logic [TAG_W:0]   rob_count,
  output logic             rob_full,
  output logic             rob_empty,
  output logic             commit_err
`ifdef ISSUE_CTRL_STATS_EN
  ,
  output logic [31:0]      stat_full_stalls,
  output logic [31:0]      stat_rs_stalls,
  output logic [15:0]      stat_flushes
`endif
);

  localparam logic [TAG_W:0]    FULL_CNT   = ROB_DEPTH[TAG_W:0];
  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYCLES - 1);

  issue_state_e      state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [TAG_W:0]    count_q, count_d;
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic              in_run;
  logic              legal_commit;
  logic              head_inc;
  regstat_wr_t       rs_wr;

  // ---------------------------------------------------------------------------
  // Tag pointers. A flush rewinds both to 0 in the same edge as count.
  // ---------------------------------------------------------------------------
  tag_ring_ptr #(.TAG_W(TAG_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .inc_i (head_inc),
    .ptr_o (head)
  );

  tag_ring_ptr #(.TAG_W(TAG_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .inc_i (issue_fire),
    .ptr_o (tail)
  );

  // ---------------------------------------------------------------------------
  // Combinational status and issue decision
  // ---------------------------------------------------------------------------
  assign in_run    = (state_q == RUN);
  assign rob_full  = (count_q == FULL_CNT);
  assign rob_empty = (count_q == '0);
  assign rob_count = count_q;

  // Full blocks issue even if the head commits this cycle: the freed slot is
  // only visible from the next cycle, which keeps tags single-live.
  assign issue_fire = in_run & instr_valid & rs_avail & ~rob_full & ~flush;

  // Commits are only meaningful in RUN; during FLUSH the ROB is being torn
  // down and stray commits are silently dropped.
  assign legal_commit = in_run & commit_valid & ~rob_empty & (commit_rob == head);
  assign commit_err   = in_run & commit_valid & ~legal_commit;
  assign head_inc     = legal_commit & ~flush;

  // Writes to x0 still consume a tag but never touch regstat.
  assign rs_wr.writes = issue_fire & instr_writes_rd & (instr_rd != 5'd0);
  assign rs_wr.dest   = instr_rd;
  assign rs_wr.rob    = tail;

  assign issue_writes  = rs_wr.writes;
  assign issue_dest    = rs_wr.dest;
  assign issue_rob     = rs_wr.rob;

  assign regstat_clear = ~in_run;
  assign stall         = ~in_run | flush | (instr_valid & ~issue_fire);

  // ---------------------------------------------------------------------------
  // Sequencer FSM and occupancy count
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    count_d = count_q;
    if (flush) begin
      // Restarts the dwell even if already flushing.
      state_d = FLUSH;
      fcnt_d  = FLUSH_INIT;
      count_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          unique case ({issue_fire, legal_commit})
            2'b10:   count_d = count_q + {{TAG_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{TAG_W{1'b0}}, 1'b1};
            default: count_d = count_q;
          endcase
        end
        FLUSH: begin
          // Leave on the cycle after the counter has reached 0, giving a
          // dwell of exactly FLUSH_CYCLES cycles.
          if (fcnt_q == '0) begin
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - {{(FCNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      count_q <= count_d;
    end
  end

`ifdef ISSUE_CTRL_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating stall / flush statistics; survive flushes, cleared by reset.
  // ---------------------------------------------------------------------------
  logic [31:0] full_stalls_q;
  logic [31:0] rs_stalls_q;
  logic [15:0] flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_stalls_q <= '0;
      rs_stalls_q   <= '0;
      flushes_q     <= '0;
    end else begin
      if (instr_valid & rob_full) begin
        full_stalls_q <= sat_inc32(full_stalls_q);
      end
      if (instr_valid & ~rs_avail & ~rob_full) begin
        rs_stalls_q <= sat_inc32(rs_stalls_q);
      end
      if (flush) begin
        flushes_q <= sat_inc16(flushes_q);
      end
    end
  end

  assign stat_full_stalls = full_stalls_q;
  assign stat_rs_stalls   = rs_stalls_q;
  assign stat_flushes     = flushes_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed scoreboard bench for issue_ctrl (FLUSH_CYCLES=2).
// Stimulus pushes the hand-computed expected outputs for each driven cycle;
// a monitor on the falling edge pops and compares them against the DUT.
module tb_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       instr_valid;
  logic       instr_writes_rd;
  logic [4:0] instr_rd;
  logic       rs_avail;
  logic       commit_valid;
  logic [3:0] commit_rob;
  logic       issue_fire;
  logic [3:0] issue_rob;
  logic       issue_writes;
  logic [4:0] issue_dest;
  logic       stall;
  logic       regstat_clear;
  logic [4:0] rob_count;
  logic       rob_full;
  logic       rob_empty;
  logic       commit_err;

  always #5 clk = ~clk;

  issue_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .instr_valid     (instr_valid),
    .instr_writes_rd (instr_writes_rd),
    .instr_rd        (instr_rd),
    .rs_avail        (rs_avail),
    .commit_valid    (commit_valid),
    .commit_rob      (commit_rob),
    .issue_fire      (issue_fire),
    .issue_rob       (issue_rob),
    .issue_writes    (issue_writes),
    .issue_dest      (issue_dest),
    .stall           (stall),
    .regstat_clear   (regstat_clear),
    .rob_count       (rob_count),
    .rob_full        (rob_full),
    .rob_empty       (rob_empty),
    .commit_err      (commit_err)
  );

  typedef struct {
    string      name;
    logic       fire;
    logic [3:0] rob;
    logic       wr;
    logic [4:0] dest;
    logic       stall;
    logic       clr;
    logic [4:0] cnt;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, expv);
    end
  endtask

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "issue_fire",    32'(issue_fire),    32'(e.fire));
      chk(e.name, "issue_rob",     32'(issue_rob),     32'(e.rob));
      chk(e.name, "issue_writes",  32'(issue_writes),  32'(e.wr));
      chk(e.name, "issue_dest",    32'(issue_dest),    32'(e.dest));
      chk(e.name, "stall",         32'(stall),         32'(e.stall));
      chk(e.name, "regstat_clear", 32'(regstat_clear), 32'(e.clr));
      chk(e.name, "rob_count",     32'(rob_count),     32'(e.cnt));
      chk(e.name, "rob_full",      32'(rob_full),      32'(e.cnt == 5'd16));
      chk(e.name, "rob_empty",     32'(rob_empty),     32'(e.cnt == 5'd0));
      chk(e.name, "commit_err",    32'(commit_err),    32'(e.err));
    end
  end

  task automatic step(input string nm,
                      input logic iv, input logic wr, input logic [4:0] rd,
                      input logic rs, input logic cv, input logic [3:0] crob,
                      input logic fl,
                      input logic e_fire, input logic [3:0] e_rob,
                      input logic e_wr, input logic e_stall, input logic e_clr,
                      input logic [4:0] e_cnt, input logic e_err);
    exp_t e;
    instr_valid     = iv;
    instr_writes_rd = wr;
    instr_rd        = rd;
    rs_avail        = rs;
    commit_valid    = cv;
    commit_rob      = crob;
    flush           = fl;
    e.name  = nm;
    e.fire  = e_fire;
    e.rob   = e_rob;
    e.wr    = e_wr;
    e.dest  = rd;
    e.stall = e_stall;
    e.clr   = e_clr;
    e.cnt   = e_cnt;
    e.err   = e_err;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    instr_valid = 1'b0;
    instr_writes_rd = 1'b0;
    instr_rd = 5'd0;
    rs_avail = 1'b0;
    commit_valid = 1'b0;
    commit_rob = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    //        name           iv wr rd    rs cv crob fl  fire rob wr st cl cnt err
    step("reset",            0, 0, 5'd0, 0, 0, 4'd0, 0,  0, 4'd0, 0, 0, 0, 5'd0, 0);

    // Fill all 16 tags back to back.
    for (int i = 0; i < 16; i++)
      step("fill",           1, 1, 5'(i + 1), 1, 0, 4'd0, 0, 1, 4'(i), 1, 0, 0, 5'(i), 0);
    step("full",             1, 1, 5'd5, 1, 0, 4'd0, 0,  0, 4'd0, 0, 1, 0, 5'd16, 0);
    // Commit at full does not bypass: issue waits one cycle.
    step("full_commit",      1, 1, 5'd6, 1, 1, 4'd0, 0,  0, 4'd0, 0, 1, 0, 5'd16, 0);
    step("after_commit",     1, 1, 5'd7, 1, 0, 4'd0, 0,  1, 4'd0, 1, 0, 0, 5'd15, 0);
    step("refull",           0, 0, 5'd0, 0, 0, 4'd0, 0,  0, 4'd1, 0, 0, 0, 5'd16, 0);
    // head=1 here; commit of tag 3 is illegal.
    step("bad_commit",       0, 0, 5'd0, 0, 1, 4'd3, 0,  0, 4'd1, 0, 0, 0, 5'd16, 1);
    step("err_pulse",        0, 0, 5'd0, 0, 0, 4'd0, 0,  0, 4'd1, 0, 0, 0, 5'd16, 0);

    // Retire tags 1..11 down to count 5.
    for (int k = 0; k < 11; k++)
      step("drain",          0, 0, 5'd0, 0, 1, 4'(k + 1), 0, 0, 4'd1, 0, 0, 0, 5'(16 - k), 0);

    // Flush with an issuable instruction present.
    step("flush",            1, 1, 5'd9, 1, 0, 4'd0, 1,  0, 4'd1, 0, 1, 0, 5'd5, 0);
    step("flush_dwell0",     1, 1, 5'd9, 1, 1, 4'd0, 0,  0, 4'd0, 0, 1, 1, 5'd0, 0);
    step("flush_dwell1",     1, 1, 5'd9, 1, 0, 4'd0, 0,  0, 4'd0, 0, 1, 1, 5'd0, 0);
    step("post_flush",       1, 1, 5'd3, 1, 0, 4'd0, 0,  1, 4'd0, 1, 0, 0, 5'd0, 0);

    // x0 destination: fires, no regstat write, tag still consumed.
    step("rd_zero",          1, 1, 5'd0, 1, 0, 4'd0, 0,  1, 4'd1, 0, 0, 0, 5'd1, 0);
    step("tag_used",         0, 0, 5'd0, 0, 0, 4'd0, 0,  0, 4'd2, 0, 0, 0, 5'd2, 0);

    // Bring tail to 15, then retire down to count 7 (head=8).
    for (int i = 0; i < 13; i++)
      step("fill2",          1, 1, 5'(i + 1), 1, 0, 4'd0, 0, 1, 4'(i + 2), 1, 0, 0, 5'(i + 2), 0);
    for (int k = 0; k < 8; k++)
      step("drain2",         0, 0, 5'd0, 0, 1, 4'(k), 0, 0, 4'd15, 0, 0, 0, 5'(15 - k), 0);

    // Simultaneous issue and commit with tail wrapping.
    step("wrap",             1, 1, 5'd4, 1, 1, 4'd8, 0,  1, 4'd15, 1, 0, 0, 5'd7, 0);
    step("wrapped",          0, 0, 5'd0, 0, 0, 4'd0, 0,  0, 4'd0, 0, 0, 0, 5'd7, 0);

    begin
      int t;
      t = 0;
      while (q.size() > 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_queue pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
